// File: rtl/execute_stage_reg.sv
// Execute-stage (E) pipeline register for the pipelined y86-64 core, with the
// load/use, mispredict, ret and halt control logic for the F/D/E registers.
module execute_stage_reg #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       d_icode,
   input  logic [3:0]       d_ifun,
   input  logic [3:0]       d_Stat,
   input  logic [63:0]      d_valC,
   input  logic [63:0]      d_valA,
   input  logic [63:0]      d_valB,
   input  logic [3:0]       d_dstE,
   input  logic [3:0]       d_dstM,
   input  logic [3:0]       d_srcA,
   input  logic [3:0]       d_srcB,
   input  logic [3:0]       M_icode,
   input  logic             e_Cnd,
   input  logic [3:0]       W_Stat,
   output logic [3:0]       E_icode,
   output logic [3:0]       E_ifun,
   output logic [3:0]       E_Stat,
   output logic [63:0]      E_valC,
   output logic [63:0]      E_valA,
   output logic [63:0]      E_valB,
   output logic [3:0]       E_dstE,
   output logic [3:0]       E_dstM,
   output logic [3:0]       E_srcA,
   output logic [3:0]       E_srcB,
   output logic             F_stall,
   output logic             D_stall,
   output logic             D_bubble,
   output logic             E_bubble,
   output logic             halted,
   output logic [CNT_W-1:0] lu_cnt,
   output logic [CNT_W-1:0] mp_cnt,
   output logic [CNT_W-1:0] ret_cnt
);
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;
   localparam logic [3:0] STAT_AOK = 4'h1;
   localparam logic [3:0] RNONE    = 4'hF;

   typedef enum logic {RUN, HALTED} state_t;

   typedef struct packed {
      logic [3:0]  icode;
      logic [3:0]  ifun;
      logic [3:0]  stat;
      logic [63:0] valc;
      logic [63:0] vala;
      logic [63:0] valb;
      logic [3:0]  dste;
      logic [3:0]  dstm;
      logic [3:0]  srca;
      logic [3:0]  srcb;
   } e_reg_t;

   localparam e_reg_t BUBBLE = '{icode: I_NOP, ifun: 4'h0, stat: STAT_AOK,
                                 valc: 64'd0, vala: 64'd0, valb: 64'd0,
                                 dste: RNONE, dstm: RNONE, srca: RNONE, srcb: RNONE};

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
      return (en && (c != {CNT_W{1'b1}})) ? c + CNT_W'(1) : c;
   endfunction

   state_t           r_state;
   e_reg_t           r_e;
   logic [CNT_W-1:0] r_lu_cnt;
   logic [CNT_W-1:0] r_mp_cnt;
   logic [CNT_W-1:0] r_ret_cnt;

   e_reg_t w_d_load;
   logic   w_load_use;
   logic   w_ret_haz;
   logic   w_mispred;

   // Decode leaves unused destinations undefined, so they are forced to RNONE here.
   always_comb begin
      w_d_load = '{icode: d_icode, ifun: d_ifun, stat: d_Stat,
                   valc: d_valC, vala: d_valA, valb: d_valB,
                   dste: RNONE, dstm: RNONE, srca: d_srcA, srcb: d_srcB};
      if (d_icode inside {I_RRMOVQ, I_IRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ})
         w_d_load.dste = d_dstE;
      if (d_icode inside {I_MRMOVQ, I_POPQ})
         w_d_load.dstm = d_dstM;
   end

   assign w_load_use = (r_e.icode inside {I_MRMOVQ, I_POPQ}) && (r_e.dstm != RNONE) &&
                       ((r_e.dstm == d_srcA) || (r_e.dstm == d_srcB));
   assign w_ret_haz  = (d_icode == I_RET) || (r_e.icode == I_RET) || (M_icode == I_RET);
   assign w_mispred  = (r_e.icode == I_JXX) && !e_Cnd;

   always_comb begin
      F_stall  = 1'b1;
      D_stall  = 1'b1;
      D_bubble = 1'b0;
      E_bubble = 1'b1;
      if (r_state == RUN) begin
         F_stall  = w_load_use | w_ret_haz;
         D_stall  = w_load_use;
         D_bubble = w_mispred | (w_ret_haz & ~w_load_use);
         E_bubble = w_mispred | w_load_use;
      end
   end

   // The edge that first sees a bad W_Stat halts and bubbles E together.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= RUN;
         r_e       <= BUBBLE;
         r_lu_cnt  <= '0;
         r_mp_cnt  <= '0;
         r_ret_cnt <= '0;
      end else begin
         if (r_state == RUN) begin
            r_lu_cnt  <= sat_inc(r_lu_cnt, w_load_use);
            r_mp_cnt  <= sat_inc(r_mp_cnt, w_mispred);
            r_ret_cnt <= sat_inc(r_ret_cnt, w_ret_haz & ~w_load_use);
            if (W_Stat != STAT_AOK)
               r_state <= HALTED;
         end
         if (E_bubble || (W_Stat != STAT_AOK))
            r_e <= BUBBLE;
         else
            r_e <= w_d_load;
      end
   end

   assign E_icode = r_e.icode;
   assign E_ifun  = r_e.ifun;
   assign E_Stat  = r_e.stat;
   assign E_valC  = r_e.valc;
   assign E_valA  = r_e.vala;
   assign E_valB  = r_e.valb;
   assign E_dstE  = r_e.dste;
   assign E_dstM  = r_e.dstm;
   assign E_srcA  = r_e.srca;
   assign E_srcB  = r_e.srcb;
   assign halted  = (r_state == HALTED);
   assign lu_cnt  = r_lu_cnt;
   assign mp_cnt  = r_mp_cnt;
   assign ret_cnt = r_ret_cnt;

endmodule

// File: tb/tb_execute_stage_reg.sv
// Bench for execute_stage_reg: directed scenarios plus random traffic checked
// against a cycle-level behavioural model of the E register and hazard rules.
module tb_execute_stage_reg;
   logic        clk;
   logic        rst;
   logic [3:0]  d_icode, d_ifun, d_Stat;
   logic [63:0] d_valC, d_valA, d_valB;
   logic [3:0]  d_dstE, d_dstM, d_srcA, d_srcB;
   logic [3:0]  M_icode;
   logic        e_Cnd;
   logic [3:0]  W_Stat;

   logic [3:0]  E_icode, E_ifun, E_Stat, E_dstE, E_dstM, E_srcA, E_srcB;
   logic [63:0] E_valC, E_valA, E_valB;
   logic        F_stall, D_stall, D_bubble, E_bubble, halted;
   logic [15:0] lu_cnt, mp_cnt, ret_cnt;

   logic [3:0]  E2_icode, E2_ifun, E2_Stat, E2_dstE, E2_dstM, E2_srcA, E2_srcB;
   logic [63:0] E2_valC, E2_valA, E2_valB;
   logic        F2_stall, D2_stall, D2_bubble, E2_bubble, halted2;
   logic [1:0]  lu_cnt2, mp_cnt2, ret_cnt2;

   int n_checks = 0;
   int n_fail   = 0;

   execute_stage_reg #(.CNT_W(16)) dut (
      .clk(clk), .rst(rst), .d_icode(d_icode), .d_ifun(d_ifun), .d_Stat(d_Stat),
      .d_valC(d_valC), .d_valA(d_valA), .d_valB(d_valB), .d_dstE(d_dstE), .d_dstM(d_dstM),
      .d_srcA(d_srcA), .d_srcB(d_srcB), .M_icode(M_icode), .e_Cnd(e_Cnd), .W_Stat(W_Stat),
      .E_icode(E_icode), .E_ifun(E_ifun), .E_Stat(E_Stat), .E_valC(E_valC), .E_valA(E_valA),
      .E_valB(E_valB), .E_dstE(E_dstE), .E_dstM(E_dstM), .E_srcA(E_srcA), .E_srcB(E_srcB),
      .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble), .E_bubble(E_bubble),
      .halted(halted), .lu_cnt(lu_cnt), .mp_cnt(mp_cnt), .ret_cnt(ret_cnt));

   execute_stage_reg #(.CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .d_icode(d_icode), .d_ifun(d_ifun), .d_Stat(d_Stat),
      .d_valC(d_valC), .d_valA(d_valA), .d_valB(d_valB), .d_dstE(d_dstE), .d_dstM(d_dstM),
      .d_srcA(d_srcA), .d_srcB(d_srcB), .M_icode(M_icode), .e_Cnd(e_Cnd), .W_Stat(W_Stat),
      .E_icode(E2_icode), .E_ifun(E2_ifun), .E_Stat(E2_Stat), .E_valC(E2_valC), .E_valA(E2_valA),
      .E_valB(E2_valB), .E_dstE(E2_dstE), .E_dstM(E2_dstM), .E_srcA(E2_srcA), .E_srcB(E2_srcB),
      .F_stall(F2_stall), .D_stall(D2_stall), .D_bubble(D2_bubble), .E_bubble(E2_bubble),
      .halted(halted2), .lu_cnt(lu_cnt2), .mp_cnt(mp_cnt2), .ret_cnt(ret_cnt2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model: E contents, halt flag and unbounded event tallies.
   logic [3:0]  mE_icode, mE_ifun, mE_stat, mE_dstE, mE_dstM, mE_srcA, mE_srcB;
   logic [63:0] mE_valC, mE_valA, mE_valB;
   bit          m_halt;
   int          raw_lu, raw_mp, raw_ret;

   function automatic int sat(input int raw, input int w);
      return (raw > (1 << w) - 1) ? (1 << w) - 1 : raw;
   endfunction

   function automatic void model_haz(output bit lu, output bit rh, output bit mp);
      lu = (mE_icode == 4'h5 || mE_icode == 4'hB) && mE_dstM != 4'hF &&
           (mE_dstM == d_srcA || mE_dstM == d_srcB);
      rh = (d_icode == 4'h9) || (mE_icode == 4'h9) || (M_icode == 4'h9);
      mp = (mE_icode == 4'h7) && !e_Cnd;
   endfunction

   function automatic logic [3:0] exp_ctl();
      bit lu, rh, mp;
      model_haz(lu, rh, mp);
      if (m_halt) return 4'b1101;
      return {lu | rh, lu, mp | (rh & !lu), mp | lu};
   endfunction

   function automatic void model_bubble();
      mE_icode = 4'h1; mE_ifun = 4'h0; mE_stat = 4'h1;
      mE_valC = 64'd0; mE_valA = 64'd0; mE_valB = 64'd0;
      mE_dstE = 4'hF; mE_dstM = 4'hF; mE_srcA = 4'hF; mE_srcB = 4'hF;
   endfunction

   function automatic void model_load();
      mE_icode = d_icode; mE_ifun = d_ifun; mE_stat = d_Stat;
      mE_valC = d_valC; mE_valA = d_valA; mE_valB = d_valB;
      mE_dstE = (d_icode inside {4'h2, 4'h3, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB}) ? d_dstE : 4'hF;
      mE_dstM = (d_icode inside {4'h5, 4'hB}) ? d_dstM : 4'hF;
      mE_srcA = d_srcA; mE_srcB = d_srcB;
   endfunction

   task automatic tick();
      bit lu, rh, mp;
      model_haz(lu, rh, mp);
      @(posedge clk);
      if (rst) begin
         model_bubble();
         m_halt = 0; raw_lu = 0; raw_mp = 0; raw_ret = 0;
      end else begin
         if (!m_halt) begin
            raw_lu  += int'(lu);
            raw_mp  += int'(mp);
            raw_ret += int'(rh && !lu);
         end
         if (m_halt || lu || mp || W_Stat != 4'h1) model_bubble();
         else model_load();
         if (W_Stat != 4'h1) m_halt = 1;
      end
      #1;
   endtask

   task automatic set_nop();
      d_icode = 4'h1; d_ifun = 4'h0; d_Stat = 4'h1;
      d_valC = 64'd0; d_valA = 64'd0; d_valB = 64'd0;
      d_dstE = 4'hF; d_dstM = 4'hF; d_srcA = 4'hF; d_srcB = 4'hF;
      M_icode = 4'h1; e_Cnd = 1'b1; W_Stat = 4'h1;
   endtask

   task automatic test_reset();
      set_nop();
      rst = 1'b1; d_icode = 4'h6; d_dstE = 4'h2; d_valA = 64'd77;
      tick(); tick();
      rst = 1'b0;
      d_icode = 4'h1;
      @(negedge clk);
      n_checks++; if (E_icode !== 4'h1) begin n_fail++; $display("FAIL reset_icode: got %0h expected 1", E_icode); end
      n_checks++; if (E_dstE !== 4'hF) begin n_fail++; $display("FAIL reset_dstE: got %0h expected f", E_dstE); end
      n_checks++; if (E_valA !== 64'd0) begin n_fail++; $display("FAIL reset_valA: got %0h expected 0", E_valA); end
      n_checks++; if ({lu_cnt, mp_cnt, ret_cnt} !== 48'd0) begin n_fail++; $display("FAIL reset_cnt: got %0h expected 0", {lu_cnt, mp_cnt, ret_cnt}); end
      n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %0b expected 0", halted); end
      n_checks++; if ({F_stall, D_stall, D_bubble, E_bubble} !== 4'b0000) begin n_fail++; $display("FAIL reset_ctl: got %b expected 0000", {F_stall, D_stall, D_bubble, E_bubble}); end
   endtask

   task automatic test_plain_flow();
      set_nop();
      d_icode = 4'h6; d_dstE = 4'h2; d_valA = 64'd5; d_dstM = 4'h7; d_srcA = 4'h0; d_srcB = 4'h1;
      tick();
      @(negedge clk);
      n_checks++; if (E_icode !== 4'h6) begin n_fail++; $display("FAIL flow_icode: got %0h expected 6", E_icode); end
      n_checks++; if (E_dstE !== 4'h2) begin n_fail++; $display("FAIL flow_dstE: got %0h expected 2", E_dstE); end
      n_checks++; if (E_dstM !== 4'hF) begin n_fail++; $display("FAIL flow_dstM: got %0h expected f", E_dstM); end
      n_checks++; if (E_valA !== 64'd5) begin n_fail++; $display("FAIL flow_valA: got %0h expected 5", E_valA); end
      n_checks++; if ({F_stall, D_stall, D_bubble, E_bubble} !== 4'b0000) begin n_fail++; $display("FAIL flow_ctl: got %b expected 0000", {F_stall, D_stall, D_bubble, E_bubble}); end
   endtask

   task automatic test_load_use();
      set_nop();
      d_icode = 4'h5; d_dstM = 4'h3; d_dstE = 4'h4; d_srcA = 4'h0; d_srcB = 4'h0;
      tick();
      d_icode = 4'h6; d_srcA = 4'h3; d_srcB = 4'h1; d_dstE = 4'h1;
      @(negedge clk);
      n_checks++; if (E_dstE !== 4'hF) begin n_fail++; $display("FAIL lu_dstE_sanitized: got %0h expected f", E_dstE); end
      n_checks++; if ({F_stall, D_stall, D_bubble, E_bubble} !== 4'b1101) begin n_fail++; $display("FAIL lu_ctl: got %b expected 1101", {F_stall, D_stall, D_bubble, E_bubble}); end
      tick();
      n_checks++; if (E_icode !== 4'h1) begin n_fail++; $display("FAIL lu_bubble: got %0h expected 1", E_icode); end
      n_checks++; if (lu_cnt !== 16'd1) begin n_fail++; $display("FAIL lu_cnt: got %0d expected 1", lu_cnt); end
   endtask

   task automatic test_mispredict();
      logic [15:0] mp0, ret0;
      set_nop();
      d_icode = 4'h7;
      tick();
      mp0 = mp_cnt; ret0 = ret_cnt;
      d_icode = 4'h9; e_Cnd = 1'b0;
      @(negedge clk);
      n_checks++; if ({F_stall, D_stall, D_bubble, E_bubble} !== 4'b1011) begin n_fail++; $display("FAIL mp_ctl: got %b expected 1011", {F_stall, D_stall, D_bubble, E_bubble}); end
      tick();
      n_checks++; if (mp_cnt !== mp0 + 16'd1) begin n_fail++; $display("FAIL mp_cnt: got %0d expected %0d", mp_cnt, mp0 + 16'd1); end
      n_checks++; if (ret_cnt !== ret0 + 16'd1) begin n_fail++; $display("FAIL mp_ret_cnt: got %0d expected %0d", ret_cnt, ret0 + 16'd1); end
      n_checks++; if (E_icode !== 4'h1) begin n_fail++; $display("FAIL mp_bubble: got %0h expected 1", E_icode); end
      set_nop();
      tick();
   endtask

   task automatic test_halt();
      logic [15:0] ret0;
      set_nop();
      d_icode = 4'h6; d_dstE = 4'h2;
      W_Stat = 4'h2;
      tick();
      W_Stat = 4'h1;
      @(negedge clk);
      n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_flag: got %0b expected 1", halted); end
      n_checks++; if (E_icode !== 4'h1) begin n_fail++; $display("FAIL halt_bubble: got %0h expected 1", E_icode); end
      n_checks++; if ({F_stall, D_stall, D_bubble, E_bubble} !== 4'b1101) begin n_fail++; $display("FAIL halt_ctl: got %b expected 1101", {F_stall, D_stall, D_bubble, E_bubble}); end
      ret0 = ret_cnt;
      d_icode = 4'h9;
      for (int i = 0; i < 3; i++) tick();
      @(negedge clk);
      n_checks++; if (halted !== 1'b1 || E_icode !== 4'h1) begin n_fail++; $display("FAIL halt_sticky: got halted=%0b icode=%0h expected 1/1", halted, E_icode); end
      n_checks++; if (ret_cnt !== ret0) begin n_fail++; $display("FAIL halt_cnt_hold: got %0d expected %0d", ret_cnt, ret0); end
      rst = 1'b1;
      tick();
      rst = 1'b0; d_icode = 4'h1;
      @(negedge clk);
      n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL halt_clear: got %0b expected 0", halted); end
      n_checks++; if ({lu_cnt, mp_cnt, ret_cnt} !== 48'd0) begin n_fail++; $display("FAIL halt_rst_cnt: got %0h expected 0", {lu_cnt, mp_cnt, ret_cnt}); end
      n_checks++; if ({F_stall, D_stall, D_bubble, E_bubble} !== 4'b0000) begin n_fail++; $display("FAIL halt_rst_ctl: got %b expected 0000", {F_stall, D_stall, D_bubble, E_bubble}); end
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 5; i++) begin
         set_nop();
         d_icode = 4'h5; d_dstM = 4'h3; d_srcA = 4'h0; d_srcB = 4'h0;
         tick();
         d_icode = 4'h6; d_srcA = 4'h3;
         tick();
      end
      set_nop();
      @(negedge clk);
      n_checks++; if (lu_cnt2 !== 2'd3) begin n_fail++; $display("FAIL sat_lu_cnt2: got %0d expected 3", lu_cnt2); end
      n_checks++; if (lu_cnt !== 16'd5) begin n_fail++; $display("FAIL sat_lu_cnt16: got %0d expected 5", lu_cnt); end
   endtask

   task automatic test_random();
      logic [3:0] pool [10] = '{4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB};
      logic [3:0] ectl;
      for (int i = 0; i < 400; i++) begin
         d_icode = pool[$urandom_range(0, 9)];
         d_ifun  = 4'($urandom_range(0, 6));
         d_Stat  = 4'h1;
         d_valC  = {$urandom, $urandom};
         d_valA  = {$urandom, $urandom};
         d_valB  = {$urandom, $urandom};
         d_dstE  = 4'($urandom_range(0, 4));
         d_dstM  = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 4));
         d_srcA  = ($urandom_range(0, 5) == 0) ? 4'hF : 4'($urandom_range(0, 4));
         d_srcB  = ($urandom_range(0, 5) == 0) ? 4'hF : 4'($urandom_range(0, 4));
         M_icode = ($urandom_range(0, 9) == 0) ? 4'h9 : 4'h1;
         e_Cnd   = 1'($urandom_range(0, 1));
         W_Stat  = 4'h1;
         rst     = ($urandom_range(0, 99) == 0);
         @(negedge clk);
         ectl = exp_ctl();
         n_checks++; if ({F_stall, D_stall, D_bubble, E_bubble} !== ectl) begin n_fail++; $display("FAIL rnd_ctl[%0d]: got %b expected %b", i, {F_stall, D_stall, D_bubble, E_bubble}, ectl); end
         n_checks++; if ({E_icode, E_ifun, E_Stat, E_dstE, E_dstM, E_srcA, E_srcB} !== {mE_icode, mE_ifun, mE_stat, mE_dstE, mE_dstM, mE_srcA, mE_srcB}) begin n_fail++; $display("FAIL rnd_efields[%0d]: got %h expected %h", i, {E_icode, E_ifun, E_Stat, E_dstE, E_dstM, E_srcA, E_srcB}, {mE_icode, mE_ifun, mE_stat, mE_dstE, mE_dstM, mE_srcA, mE_srcB}); end
         n_checks++; if ({E_valC, E_valA, E_valB} !== {mE_valC, mE_valA, mE_valB}) begin n_fail++; $display("FAIL rnd_evals[%0d]: got %h expected %h", i, {E_valC, E_valA, E_valB}, {mE_valC, mE_valA, mE_valB}); end
         n_checks++; if ({lu_cnt, mp_cnt, ret_cnt} !== {16'(sat(raw_lu, 16)), 16'(sat(raw_mp, 16)), 16'(sat(raw_ret, 16))}) begin n_fail++; $display("FAIL rnd_cnt[%0d]: got %0d/%0d/%0d expected %0d/%0d/%0d", i, lu_cnt, mp_cnt, ret_cnt, raw_lu, raw_mp, raw_ret); end
         n_checks++; if ({lu_cnt2, mp_cnt2, ret_cnt2} !== {2'(sat(raw_lu, 2)), 2'(sat(raw_mp, 2)), 2'(sat(raw_ret, 2))}) begin n_fail++; $display("FAIL rnd_cnt2[%0d]: got %0d/%0d/%0d expected sat of %0d/%0d/%0d", i, lu_cnt2, mp_cnt2, ret_cnt2, raw_lu, raw_mp, raw_ret); end
         tick();
      end
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      set_nop();
      model_bubble();
      m_halt = 0; raw_lu = 0; raw_mp = 0; raw_ret = 0;
      test_reset();
      test_plain_flow();
      test_load_use();
      test_mispredict();
      test_halt();
      test_saturation();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/execute_stage_reg.md
# execute_stage_reg

Execute-stage pipeline register (E register) plus pipeline hazard control for the pipelined y86-64 core. It captures the decode-stage outputs (`d_*`) on each clock edge. It inserts bubbles for load/use hazards, mispredicted jumps and halting exceptions. It generates the stall/bubble signals for the F and D registers. It sits between the decode/write-back stage and the ALU stage, and keeps saturating hazard counters for performance debug.

## Interface
- `CNT_W`, 16: width of each hazard counter.
- `clk`  in  1  single system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `d_icode`, `d_ifun`, `d_Stat`  in  4 each  decode-stage instruction code, function and status.
- `d_valC`, `d_valA`, `d_valB`  in  64 each  decode-stage constant and forwarded operands.
- `d_dstE`, `d_dstM`, `d_srcA`, `d_srcB`  in  4 each  decode-stage register IDs; 15 = RNONE.
- `M_icode`  in  4  icode currently in the M register.
- `e_Cnd`  in  1  branch condition computed by the execute stage for `E_icode`.
- `W_Stat`  in  4  status in the W register.
- `E_icode`, `E_ifun`, `E_Stat`  out  4 each  registered instruction fields.
- `E_valC`, `E_valA`, `E_valB`  out  64 each  registered operands.
- `E_dstE`, `E_dstM`, `E_srcA`, `E_srcB`  out  4 each  registered register IDs.
- `F_stall`, `D_stall`, `D_bubble`, `E_bubble`  out  1 each  pipeline control, combinational.
- `halted`  out  1  sticky halt state.
- `lu_cnt`, `mp_cnt`, `ret_cnt`  out  CNT_W each  load/use, mispredict and ret-stall cycle counters.

## Operation
- Encodings:
  - icode: NOP=1, RRMOVQ=2, IRMOVQ=3, MRMOVQ=5, OPQ=6, JXX=7, CALL=8, RET=9, PUSHQ=A, POPQ=B.
  - Stat: AOK=1.
  - RNONE=15.
- Bubble value: icode=1, ifun=0, Stat=1, valC/valA/valB=0, dstE/dstM/srcA/srcB=15.
- Destination sanitization on load (decode drives X for unused destinations):
  - `E_dstE` ← `d_dstE` only when `d_icode` ∈ {2,3,6,8,9,A,B}; otherwise 15.
  - `E_dstM` ← `d_dstM` only when `d_icode` ∈ {5,B}; otherwise 15.
- Hazard terms (combinational):
  - load_use = (`E_icode` ∈ {5,B}) && `E_dstM`≠15 && (`E_dstM`==`d_srcA` || `E_dstM`==`d_srcB`).
  - ret_haz = RET ∈ {`d_icode`, `E_icode`, `M_icode`}.
  - mispred = `E_icode`==JXX && !`e_Cnd`.
- Control outputs while RUN:
  - `F_stall` = load_use | ret_haz.
  - `D_stall` = load_use.
  - `D_bubble` = mispred | (ret_haz & !load_use).
  - `E_bubble` = mispred | load_use.
- Control outputs while HALTED: `F_stall`=`D_stall`=1, `D_bubble`=0, `E_bubble`=1.
- State machine: RUN → HALTED when `W_Stat`≠AOK at a clock edge. HALTED is sticky until `rst`. `halted`=1 in HALTED.
- E register update at each edge:
  - `rst`: bubble value.
  - HALTED or `E_bubble`: bubble value.
  - otherwise: load `d_*`. The E register has no stall.
- Counters, in RUN only:
  - `lu_cnt` +1 per edge with load_use.
  - `mp_cnt` +1 per edge with mispred.
  - `ret_cnt` +1 per edge with ret_haz & !load_use.
  - All saturate at 2^CNT_W−1 and hold in HALTED.
- Simultaneous events:
  - mispred + ret in D: F_stall=1, D_bubble=1, E_bubble=1.
  - load_use + ret in D: F_stall=1, D_stall=1, E_bubble=1, D_bubble=0; `ret_cnt` does not increment.
  - Both conditions in the same cycle increment both counters.

## Timing
- Reset, on the first edge with `rst`=1:
  - E outputs = bubble value; state RUN; `halted`=0; counters 0.
  - Control outputs then follow the bubble E contents (all 0 if d_icode≠RET).
- Reset mid-operation overrides HALTED and any pending hazard on the same edge.
- Latency: `d_*` → `E_*` one cycle.
- Control outputs are combinational from current `d_*`, `E_*`, `M_icode` and `e_Cnd`. They are valid in the same cycle, with no registered delay.
- HALTED takes effect on the edge where `W_Stat`≠AOK is sampled. A bubble is loaded into E on that same edge.
- Counter saturation: at max value a further event leaves the count unchanged, with no wrap.

## Test plan
- Reset: assert `rst` for 2 cycles with `d_icode`=6 → `E_icode`=1, `E_dstE`=15, `E_valA`=0, counters 0, `halted`=0.
- Plain flow: `d_icode`=6, `d_dstE`=2, `d_valA`=5, `d_dstM`=X → next cycle `E_icode`=6, `E_dstE`=2, `E_dstM`=15, `E_valA`=5, all controls 0.
- Load/use: E holds mrmovq with `E_dstM`=3, and `d_srcA`=3 → F_stall=D_stall=E_bubble=1, D_bubble=0; next `E_icode`=1; `lu_cnt`=1.
- Mispredict: E holds jXX with `e_Cnd`=0 and ret in D → F_stall=1, D_bubble=1, E_bubble=1; `mp_cnt` and `ret_cnt` each +1.
- Halt: `W_Stat`=2 for one cycle then 1 → `halted`=1 permanently, E holds bubble, F_stall=D_stall=1; `rst` pulse clears all of it.
- Saturation: CNT_W=2, 5 consecutive load/use cycles → `lu_cnt`=3.
